// File: rtl/polara_loopback_pkg.sv
// Shared definitions for the Polara NoC loopback generator and checker.
// Both ends import this package so that the injected and expected data
// patterns, the FSM encodings and the nominal packet length stay in step.
package polara_loopback_pkg;

    // Checker FSM: S_HDR waits for a header, S_PAY walks the payload flits.
    typedef enum logic [0:0] {
        S_HDR = 1'b0,
        S_PAY = 1'b1
    } chk_state_e;

    // Default alternating payload pattern, replicated across the flit width:
    // even-indexed flits are all ones, odd-indexed flits are all zeros.
    localparam logic DEF_PAT_A_BIT = 1'b1;
    localparam logic DEF_PAT_B_BIT = 1'b0;

    // Nominal payload length (in flits) emitted by the generator.
    localparam int DEF_EXP_LEN = 6;

endpackage

// File: rtl/polara_sat_counter.sv
// Saturating up-counter with synchronous clear. Clear has priority over
// increment, and the count holds at all ones instead of wrapping.
module polara_sat_counter #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear wins, otherwise step unless already saturated.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/polara_loopback_checker.sv
// Chipset-side checker for NoC flits looped back from the Polara chip.
// Packets are delimited by the header length field; every payload flit is
// compared against the alternating PAT_A/PAT_B pattern. Packet and error
// counts saturate, and the first failing flit is captured for debug.
// Optional header check (type and length) is compiled in when the macro
// POLARA_LOOPBACK_CHK_HDR_EN is defined.
//
// Handshake: a flit is transferred on a rising edge where in_val and in_rdy
// are both high. in_rdy follows chk_en (and is low during reset); in_val and
// in_data are only sampled on such a transfer.

// Header field positions normally come from define.tmp.h.
`ifndef NOC_DATA_WIDTH
`define NOC_DATA_WIDTH 64
`endif
`ifndef MSG_LENGTH
`define MSG_LENGTH 29:22
`endif
`ifndef MSG_TYPE
`define MSG_TYPE 21:14
`endif
`ifndef MSG_TYPE_INV_FWD
`define MSG_TYPE_INV_FWD 8'd16
`endif

module polara_loopback_checker
    import polara_loopback_pkg::*;
#(
    parameter int                DATA_W  = `NOC_DATA_WIDTH,
    parameter int                CNT_W   = 32,
    parameter int                EXP_LEN = DEF_EXP_LEN,
    parameter logic [DATA_W-1:0] PAT_A   = {DATA_W{DEF_PAT_A_BIT}},
    parameter logic [DATA_W-1:0] PAT_B   = {DATA_W{DEF_PAT_B_BIT}}
) (
    input  logic              chipset_clk,
    input  logic              chipset_rst_n,
    input  logic              chk_en,
    input  logic              chk_clr,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_val,
    output logic              in_rdy,
    output logic [CNT_W-1:0]  pkt_cnt,
    output logic [CNT_W-1:0]  err_cnt,
    output logic              err_sticky,
    output logic [DATA_W-1:0] err_flit,
    output logic              busy
);

    // The expected length is compared against the 8-bit length field.
    if (EXP_LEN < 0 || EXP_LEN > 255) begin : g_bad_exp_len
        $error("EXP_LEN must fit the 8-bit header length field");
    end

    chk_state_e        state_q, state_d;
    logic [7:0]        idx_q, idx_d;
    logic [7:0]        len_q, len_d;
    logic              sticky_q, sticky_d;
    logic [DATA_W-1:0] flit_q, flit_d;

    logic              xfer;
    logic              pkt_inc;
    logic              err_inc;
    logic [7:0]        hdr_len;
    logic [DATA_W-1:0] exp_pat;

    assign in_rdy  = chk_en & chipset_rst_n;
    assign xfer    = in_val & in_rdy;
    assign hdr_len = in_data[`MSG_LENGTH];
    assign exp_pat = idx_q[0] ? PAT_B : PAT_A;

    // Packet walker: header latches the length, payload flits are checked.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        pkt_inc = 1'b0;
        err_inc = 1'b0;
        if (xfer) begin
            case (state_q)
                S_HDR: begin
                    len_d = hdr_len;
`ifdef POLARA_LOOPBACK_CHK_HDR_EN
                    // Type and length faults together count as one error.
                    err_inc = (in_data[`MSG_TYPE] != `MSG_TYPE_INV_FWD) ||
                              (hdr_len != EXP_LEN[7:0]);
`else
                    // Header is used only to find the packet length.
                    err_inc = 1'b0;
`endif
                    if (hdr_len == 8'd0) begin
                        pkt_inc = 1'b1;
                    end else begin
                        idx_d   = 8'd0;
                        state_d = S_PAY;
                    end
                end
                S_PAY: begin
                    err_inc = (in_data != exp_pat);
                    if (idx_q == (len_q - 8'd1)) begin
                        pkt_inc = 1'b1;
                        idx_d   = 8'd0;
                        state_d = S_HDR;
                    end else begin
                        idx_d = idx_q + 8'd1;
                    end
                end
            endcase
        end
    end

    // Debug capture: clear wins over a coincident error; only the first
    // error after a clear is captured.
    always_comb begin
        sticky_d = sticky_q | err_inc;
        flit_d   = (err_inc && !sticky_q) ? in_data : flit_q;
        if (chk_clr) begin
            sticky_d = 1'b0;
            flit_d   = '0;
        end
    end

    // State and debug registers; reset discards any partial packet.
    always_ff @(posedge chipset_clk or negedge chipset_rst_n) begin
        if (!chipset_rst_n) begin
            state_q  <= S_HDR;
            idx_q    <= 8'd0;
            len_q    <= 8'd0;
            sticky_q <= 1'b0;
            flit_q   <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            len_q    <= len_d;
            sticky_q <= sticky_d;
            flit_q   <= flit_d;
        end
    end

    polara_sat_counter #(.W(CNT_W)) u_pkt_cnt (
        .clk_i  (chipset_clk),
        .rst_ni (chipset_rst_n),
        .clr_i  (chk_clr),
        .inc_i  (pkt_inc),
        .cnt_o  (pkt_cnt)
    );

    polara_sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk_i  (chipset_clk),
        .rst_ni (chipset_rst_n),
        .clr_i  (chk_clr),
        .inc_i  (err_inc),
        .cnt_o  (err_cnt)
    );

    assign err_sticky = sticky_q;
    assign err_flit   = flit_q;
    assign busy       = (state_q == S_PAY);

endmodule

// File: tb/tb_polara_loopback_checker.sv
// Self-checking bench for polara_loopback_checker. Each accepted flit pushes
// the expected status into a queue, which is popped and compared half a
// cycle after the accepting edge. A second instance with 4-bit counters
// covers saturation.
`ifndef NOC_DATA_WIDTH
`define NOC_DATA_WIDTH 64
`endif
`ifndef MSG_LENGTH
`define MSG_LENGTH 29:22
`endif
`ifndef MSG_TYPE
`define MSG_TYPE 21:14
`endif
`ifndef MSG_TYPE_INV_FWD
`define MSG_TYPE_INV_FWD 8'd16
`endif

module tb_polara_loopback_checker;

    localparam int DW = `NOC_DATA_WIDTH;
    localparam int CW = 32;
    localparam int SW = 4;
    localparam int EW = 1 + DW + 1 + CW + CW;
`ifdef POLARA_LOOPBACK_CHK_HDR_EN
    localparam bit HDR_CHK = 1'b1;
`else
    localparam bit HDR_CHK = 1'b0;
`endif
    localparam logic [DW-1:0] PA = {DW{1'b1}};
    localparam logic [DW-1:0] PB = {DW{1'b0}};

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          rst_n;
    logic          chk_en;
    logic          chk_clr;
    logic          sat_clr;
    logic [DW-1:0] in_data;
    logic          in_val;
    logic          in_rdy, in_rdy_s;
    logic [CW-1:0] pkt_cnt, err_cnt;
    logic [SW-1:0] pkt_cnt_s, err_cnt_s;
    logic          err_sticky, err_sticky_s;
    logic [DW-1:0] err_flit, err_flit_s;
    logic          busy, busy_s;

    always #5 clk = ~clk;

    polara_loopback_checker #(.DATA_W(DW), .CNT_W(CW)) dut (
        .chipset_clk   (clk),
        .chipset_rst_n (rst_n),
        .chk_en        (chk_en),
        .chk_clr       (chk_clr),
        .in_data       (in_data),
        .in_val        (in_val),
        .in_rdy        (in_rdy),
        .pkt_cnt       (pkt_cnt),
        .err_cnt       (err_cnt),
        .err_sticky    (err_sticky),
        .err_flit      (err_flit),
        .busy          (busy)
    );

    polara_loopback_checker #(.DATA_W(DW), .CNT_W(SW)) dut_sat (
        .chipset_clk   (clk),
        .chipset_rst_n (rst_n),
        .chk_en        (chk_en),
        .chk_clr       (sat_clr),
        .in_data       (in_data),
        .in_val        (in_val),
        .in_rdy        (in_rdy_s),
        .pkt_cnt       (pkt_cnt_s),
        .err_cnt       (err_cnt_s),
        .err_sticky    (err_sticky_s),
        .err_flit      (err_flit_s),
        .busy          (busy_s)
    );

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q[$];
    int            n_vec = 0;
    int            n_bad = 0;

    // Expected status of the main instance, stepped per driven flit.
    logic [CW-1:0] m_pkt;
    logic [CW-1:0] m_err;
    logic          m_sticky;
    logic [DW-1:0] m_flit;

    function automatic logic [DW-1:0] make_hdr(input int len);
        logic [DW-1:0] h;
        h = '0;
        h[`MSG_LENGTH] = len[7:0];
        h[`MSG_TYPE]   = `MSG_TYPE_INV_FWD;
        return h;
    endfunction

    task automatic model_zero();
        m_pkt    = '0;
        m_err    = '0;
        m_sticky = 1'b0;
        m_flit   = '0;
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        in_val  = 1'b0;
        chk_clr = 1'b0;
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    // Drive one flit (called at a negedge), record what the checker must
    // report afterwards, then compare on the following negedge.
    task automatic send_flit(input logic [DW-1:0] d, input bit bad, input bit last,
                             input bit busy_after, input bit clr);
        logic [EW-1:0] e;
        in_data = d;
        in_val  = 1'b1;
        chk_clr = clr;
        if (clr) begin
            model_zero();
        end else begin
            if (bad) begin
                if (m_err != {CW{1'b1}}) m_err = m_err + 1;
                if (!m_sticky) m_flit = d;
                m_sticky = 1'b1;
            end
            if (last && (m_pkt != {CW{1'b1}})) m_pkt = m_pkt + 1;
        end
        exp_q.push_back({busy_after, m_flit, m_sticky, m_err, m_pkt});
        @(posedge clk);
        @(negedge clk);
        chk_clr = 1'b0;
        e = exp_q.pop_front();
        n_vec++;
        if (pkt_cnt !== e[CW-1:0]) begin
            n_bad++;
            $display("FAIL sb_pkt_cnt got=%0d exp=%0d t=%0t", pkt_cnt, e[CW-1:0], $time);
        end
        n_vec++;
        if (err_cnt !== e[2*CW-1:CW]) begin
            n_bad++;
            $display("FAIL sb_err_cnt got=%0d exp=%0d t=%0t", err_cnt, e[2*CW-1:CW], $time);
        end
        n_vec++;
        if (err_sticky !== e[2*CW]) begin
            n_bad++;
            $display("FAIL sb_err_sticky got=%0b exp=%0b t=%0t", err_sticky, e[2*CW], $time);
        end
        n_vec++;
        if (err_flit !== e[2*CW+DW:2*CW+1]) begin
            n_bad++;
            $display("FAIL sb_err_flit got=%h exp=%h t=%0t", err_flit, e[2*CW+DW:2*CW+1], $time);
        end
        n_vec++;
        if (busy !== e[EW-1]) begin
            n_bad++;
            $display("FAIL sb_busy got=%0b exp=%0b t=%0t", busy, e[EW-1], $time);
        end
    endtask

    // Header plus len payload flits; bad_idx >= 0 replaces that flit.
    task automatic send_pkt(input int len, input int bad_idx, input logic [DW-1:0] bad_val,
                            input bit clr_last);
        logic [DW-1:0] d;
        bit            hbad;
        hbad = HDR_CHK && (len != 6);
        send_flit(make_hdr(len), hbad, len == 0, len != 0, clr_last && (len == 0));
        for (int i = 0; i < len; i++) begin
            d = (i % 2 == 0) ? PA : PB;
            if (i == bad_idx) d = bad_val;
            send_flit(d, i == bad_idx, i == len - 1, i != len - 1, clr_last && (i == len - 1));
        end
    endtask

    task automatic do_clear();
        in_val  = 1'b0;
        chk_clr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_clr = 1'b0;
        model_zero();
        n_vec++;
        if ({pkt_cnt, err_cnt, err_sticky, err_flit} !== '0) begin
            n_bad++;
            $display("FAIL clear pkt=%0d err=%0d sticky=%0b flit=%h exp all zero",
                     pkt_cnt, err_cnt, err_sticky, err_flit);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n   = 1'b0;
        chk_en  = 1'b1;
        chk_clr = 1'b0;
        sat_clr = 1'b0;
        in_val  = 1'b0;
        in_data = '0;
        model_zero();
        repeat (3) @(negedge clk);
        n_vec++;
        if ({in_rdy, busy, err_sticky} !== 3'b000 || pkt_cnt !== '0 || err_cnt !== '0 ||
            err_flit !== '0) begin
            n_bad++;
            $display("FAIL reset_values rdy=%0b busy=%0b sticky=%0b pkt=%0d err=%0d flit=%h exp all zero",
                     in_rdy, busy, err_sticky, pkt_cnt, err_cnt, err_flit);
        end
        rst_n = 1'b1;
        #1;
        n_vec++;
        if (in_rdy !== 1'b1) begin
            n_bad++;
            $display("FAIL rdy_after_reset got=%0b exp=1", in_rdy);
        end
    endtask

    task automatic test_clean();
        for (int p = 0; p < 10; p++) send_pkt(6, -1, '0, 1'b0);
        n_vec++;
        if (pkt_cnt !== 32'd10 || err_cnt !== 32'd0 || err_sticky !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL clean_end pkt=%0d err=%0d sticky=%0b busy=%0b exp 10/0/0/0",
                     pkt_cnt, err_cnt, err_sticky, busy);
        end
        idle(1);
    endtask

    task automatic test_single_fault();
        logic [DW-1:0] fe;
        fe = {{(DW-8){1'b1}}, 8'hFE};
        do_clear();
        send_pkt(6, -1, '0, 1'b0);
        send_pkt(6, -1, '0, 1'b0);
        send_pkt(6, 2, fe, 1'b0);
        n_vec++;
        if (err_cnt !== 32'd1 || err_sticky !== 1'b1 || err_flit !== fe || pkt_cnt !== 32'd3) begin
            n_bad++;
            $display("FAIL single_fault err=%0d sticky=%0b flit=%h pkt=%0d exp 1/1/%h/3",
                     err_cnt, err_sticky, err_flit, pkt_cnt, fe);
        end
    endtask

    task automatic test_two_faults();
        logic [DW-1:0] x, y;
        x = PB ^ DW'(64'h00A5);
        y = PA ^ DW'(64'hF0F0_0000_0000_0001);
        do_clear();
        send_pkt(6, 1, x, 1'b0);
        send_pkt(6, 4, y, 1'b0);
        n_vec++;
        if (err_cnt !== 32'd2 || err_flit !== x) begin
            n_bad++;
            $display("FAIL two_faults err=%0d flit=%h exp 2/%h", err_cnt, err_flit, x);
        end
    endtask

    task automatic test_clear_last();
        send_pkt(6, -1, '0, 1'b1);
        send_pkt(6, -1, '0, 1'b0);
        n_vec++;
        if (pkt_cnt !== 32'd1 || err_cnt !== 32'd0 || err_sticky !== 1'b0) begin
            n_bad++;
            $display("FAIL clear_then_pkt pkt=%0d err=%0d sticky=%0b exp 1/0/0",
                     pkt_cnt, err_cnt, err_sticky);
        end
    endtask

    task automatic test_stall();
        logic [CW-1:0] pkt_before;
        send_flit(make_hdr(6), 1'b0, 1'b0, 1'b1, 1'b0);
        send_flit(PA, 1'b0, 1'b0, 1'b1, 1'b0);
        send_flit(PB, 1'b0, 1'b0, 1'b1, 1'b0);
        pkt_before = m_pkt;
        chk_en  = 1'b0;
        in_data = make_hdr(0);
        in_val  = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            @(negedge clk);
            n_vec++;
            if (in_rdy !== 1'b0 || busy !== 1'b1 || pkt_cnt !== pkt_before) begin
                n_bad++;
                $display("FAIL stall c=%0d rdy=%0b busy=%0b pkt=%0d exp 0/1/%0d",
                         c, in_rdy, busy, pkt_cnt, pkt_before);
            end
        end
        chk_en = 1'b1;
        send_flit(PA, 1'b0, 1'b0, 1'b1, 1'b0);
        send_flit(PB, 1'b0, 1'b0, 1'b1, 1'b0);
        send_flit(PA, 1'b0, 1'b0, 1'b1, 1'b0);
        send_flit(PB, 1'b0, 1'b1, 1'b0, 1'b0);
        n_vec++;
        if (pkt_cnt !== pkt_before + 1 || err_cnt !== m_err) begin
            n_bad++;
            $display("FAIL stall_resume pkt=%0d err=%0d exp %0d/%0d",
                     pkt_cnt, err_cnt, pkt_before + 1, m_err);
        end
    endtask

    task automatic test_zero_len();
        send_pkt(0, -1, '0, 1'b0);
        send_pkt(1, -1, '0, 1'b0);
        send_pkt(2, 1, PA, 1'b0);
    endtask

    task automatic test_header_check();
        do_clear();
        send_pkt(4, -1, '0, 1'b0);
        n_vec++;
        if (err_cnt !== (HDR_CHK ? 32'd1 : 32'd0) || pkt_cnt !== 32'd1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL header_check err=%0d pkt=%0d busy=%0b exp %0d/1/0",
                     err_cnt, pkt_cnt, busy, HDR_CHK ? 1 : 0);
        end
        send_pkt(6, -1, '0, 1'b0);
    endtask

    task automatic test_reset_mid_packet();
        send_flit(make_hdr(6), 1'b0, 1'b0, 1'b1, 1'b0);
        send_flit(PA, 1'b0, 1'b0, 1'b1, 1'b0);
        send_flit(DW'(64'h5), 1'b1, 1'b0, 1'b1, 1'b0);
        in_val = 1'b0;
        rst_n  = 1'b0;
        #1;
        n_vec++;
        if ({in_rdy, busy, err_sticky} !== 3'b000 || pkt_cnt !== '0 || err_cnt !== '0 ||
            err_flit !== '0) begin
            n_bad++;
            $display("FAIL reset_mid rdy=%0b busy=%0b sticky=%0b pkt=%0d err=%0d flit=%h exp all zero",
                     in_rdy, busy, err_sticky, pkt_cnt, err_cnt, err_flit);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_zero();
        send_pkt(6, -1, '0, 1'b0);
    endtask

    task automatic test_saturation();
        idle(1);
        sat_clr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        sat_clr = 1'b0;
        n_vec++;
        if (pkt_cnt_s !== 4'd0) begin
            n_bad++;
            $display("FAIL sat_clear got=%0d exp=0", pkt_cnt_s);
        end
        for (int p = 0; p < 20; p++) begin
            send_pkt(6, -1, '0, 1'b0);
            if (p == 14) begin
                n_vec++;
                if (pkt_cnt_s !== 4'd15) begin
                    n_bad++;
                    $display("FAIL sat_at_15 got=%0d exp=15", pkt_cnt_s);
                end
            end
        end
        n_vec++;
        if (pkt_cnt_s !== 4'd15 || err_cnt_s !== 4'd0) begin
            n_bad++;
            $display("FAIL sat_hold pkt=%0d err=%0d exp 15/0", pkt_cnt_s, err_cnt_s);
        end
        idle(1);
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_clean();
        test_single_fault();
        test_two_faults();
        test_clear_last();
        test_stall();
        test_zero_len();
        test_header_check();
        test_reset_mid_packet();
        test_saturation();
        n_vec++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL sb_leftover got=%0d exp=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
